// File: rtl/cgra_config_sequencer.sv
// Handshaked controller for one CGRA kernel invocation. It accepts configuration
// beats, replays each one for a single cycle on the fabric config bus, runs the
// datapath for a programmed budget, and then pulses done.
module cgra_config_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int CFG_GAP = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [CNT_W-1:0]  run_cycles_in,
  input  logic              abort_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              run_en_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [CNT_W-1:0]  run_count_out
);

  localparam int GAP_W = (CFG_GAP > 0) ? $clog2(CFG_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CFG_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_budget;
  logic [CNT_W-1:0]   r_run_count;
  logic [GAP_W-1:0]   r_gap;
  logic [ADDR_W-1:0]  r_cfg_addr;
  logic [DATA_W-1:0]  r_cfg_data;

  logic w_start_acc;
  logic w_beat_acc;
  logic w_run_last;
  logic w_ready;
  logic w_run_en;
  logic w_busy;
  logic w_done;

  // Abort wins over start and beat acceptance, so nothing new is latched and
  // a beat offered in the abort cycle never reaches the fabric.
  assign w_start_acc = (r_state == S_IDLE) && start_in && !abort_in;
  assign w_beat_acc  = w_ready && cfg_valid_in && !abort_in;
  // The budget is at least 1 whenever RUN is entered, so the subtraction cannot wrap.
  assign w_run_last  = (r_run_count >= (r_budget - CNT_W'(1)));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven in this block gets a default before the case,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_run_en    = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_done      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_in) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_ready = (r_gap == '0);
        if (w_ready && cfg_valid_in && cfg_last_in) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nxt = (r_budget == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_run_en = 1'b1;
        if (w_run_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort_in) w_state_nxt = S_IDLE;
  end

  // NOTE: the config bus registers are reset explicitly because the fabric
  // treats any nonzero address as a live write, even straight out of reset.
  always_ff @(posedge clk_in) begin
    if (reset_in || abort_in) begin
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
    end else if (w_beat_acc) begin
      r_cfg_addr <= cfg_addr_in;
      r_cfg_data <= cfg_data_in;
    end else begin
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
    end
  end

  // The gap counter holds off ready for CFG_GAP cycles after every accepted beat.
  always_ff @(posedge clk_in) begin
    if (reset_in || abort_in) begin
      r_gap <= '0;
    end else if (w_beat_acc) begin
      r_gap <= GAP_LOAD;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GAP_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_budget <= '0;
    end else if (w_start_acc) begin
      r_budget <= run_cycles_in;
    end
  end

  // The count survives abort and DONE so the host can read it back afterwards.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_run_count <= '0;
    end else if (w_start_acc) begin
      r_run_count <= '0;
    end else if ((r_state == S_RUN) && !abort_in && (r_run_count < r_budget)) begin
      r_run_count <= r_run_count + CNT_W'(1);
    end
  end

  assign cfg_ready_out   = w_ready;
  assign config_addr_out = r_cfg_addr;
  assign config_data_out = r_cfg_data;
  assign run_en_out      = w_run_en;
  assign busy_out        = w_busy;
  assign done_out        = w_done;
  assign run_count_out   = r_run_count;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Self-checking bench for cgra_config_sequencer: directed vector table, directed
// corner sequences, and random transactions checked against a timing model.
module tb_cgra_config_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          reset_in;
  logic          start_in;
  logic [CW-1:0] run_cycles_in;
  logic          abort_in;
  logic          cfg_valid_in;
  logic [AW-1:0] cfg_addr_in;
  logic [DW-1:0] cfg_data_in;
  logic          cfg_last_in;

  logic          ready0, run0, busy0, done0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic [CW-1:0] cnt0;
  logic          ready2, run2, busy2, done2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] data2;
  logic [CW-1:0] cnt2;

  cgra_config_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .CFG_GAP(0)) dut0 (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
    .run_cycles_in(run_cycles_in), .abort_in(abort_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(ready0),
    .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
    .config_addr_out(addr0), .config_data_out(data0), .run_en_out(run0),
    .busy_out(busy0), .done_out(done0), .run_count_out(cnt0)
  );

  cgra_config_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .CFG_GAP(2)) dut2 (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
    .run_cycles_in(run_cycles_in), .abort_in(abort_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(ready2),
    .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
    .config_addr_out(addr2), .config_data_out(data2), .run_en_out(run2),
    .busy_out(busy2), .done_out(done2), .run_count_out(cnt2)
  );

  // sel chooses which instance is checked; both see the same stimulus.
  bit            sel;
  logic          o_ready, o_run, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_cnt;
  assign o_ready = sel ? ready2 : ready0;
  assign o_run   = sel ? run2   : run0;
  assign o_busy  = sel ? busy2  : busy0;
  assign o_done  = sel ? done2  : done0;
  assign o_addr  = sel ? addr2  : addr0;
  assign o_data  = sel ? data2  : data0;
  assign o_cnt   = sel ? cnt2   : cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic          start;
    logic [CW-1:0] run;
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          e_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_run;
    logic          e_busy;
    logic          e_done;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic st, input int run, input logic v, input int a,
                              input int d, input logic l, input logic er, input int ea,
                              input int ed, input logic eru, input logic eb, input logic edn,
                              input int ec);
    vec_t r;
    r.start = st;  r.run = CW'(run); r.valid = v; r.addr = AW'(a); r.data = DW'(d);
    r.last = l;    r.e_ready = er;   r.e_addr = AW'(ea); r.e_data = DW'(ed);
    r.e_run = eru; r.e_busy = eb;    r.e_done = edn; r.e_cnt = CW'(ec);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input string p, input logic er, input logic [AW-1:0] ea,
                            input logic [DW-1:0] ed, input logic eru, input logic eb,
                            input logic edn, input logic [CW-1:0] ec);
    check({p, ".ready"}, 64'(o_ready), 64'(er));
    check({p, ".addr"},  64'(o_addr),  64'(ea));
    check({p, ".data"},  64'(o_data),  64'(ed));
    check({p, ".run_en"}, 64'(o_run),  64'(eru));
    check({p, ".busy"},  64'(o_busy),  64'(eb));
    check({p, ".done"},  64'(o_done),  64'(edn));
    check({p, ".count"}, 64'(o_cnt),   64'(ec));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    start_in = 1'b0; run_cycles_in = '0; abort_in = 1'b0;
    cfg_valid_in = 1'b0; cfg_addr_in = '0; cfg_data_in = '0; cfg_last_in = 1'b0;
  endtask

  task automatic do_reset(input string p);
    idle_inputs();
    reset_in = 1'b1;
    tick();
    check_outs(p, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    reset_in = 1'b0;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    cfg_valid_in = 1'b1; cfg_addr_in = a; cfg_data_in = d; cfg_last_in = l;
  endtask

  // Reference model: after the last beat is accepted at t with budget N, run_en
  // covers t+2..t+N+1, done is at t+N+2, idle at t+N+3; every accepted beat is
  // seen on the bus exactly one cycle later; ready reopens CFG_GAP+1 cycles
  // after an accept.  poke asserts start during RUN/DONE, which must be ignored.
  task automatic run_txn(input int nb, input int budget, input int vpct, input bit poke);
    logic [AW-1:0] ba[8];
    logic [DW-1:0] bd[8];
    int gap, k, t_last, last_acc, acc_prev, r0, ec;
    bit ended, v, er, eru, eb, edn;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    gap = sel ? 2 : 0;
    k = 0; t_last = -1; last_acc = -1000; acc_prev = -1; ended = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ba[i] = $urandom;
      if (ba[i] == '0) ba[i] = AW'(1);
      bd[i] = $urandom;
    end
    check("txn.idle_before_start", 64'(o_busy), 64'(0));
    start_in = 1'b1;
    run_cycles_in = CW'(budget);
    send_beat(AW'(32'hDEAD_0001), DW'(32'hBAD0_BAD0), 1'b0);
    check("txn.ready_in_idle", 64'(o_ready), 64'(0));
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      ea = (acc_prev >= 0) ? ba[acc_prev] : '0;
      ed = (acc_prev >= 0) ? bd[acc_prev] : '0;
      er = (t_last < 0) && ((cyc - last_acc) > gap);
      if (t_last >= 0) begin
        r0  = t_last + 2;
        eru = (cyc >= r0) && (cyc <= t_last + budget + 1);
        edn = (cyc == t_last + budget + 2);
        eb  = (cyc <= t_last + budget + 2);
        ec  = (cyc < r0) ? 0 : (((cyc - r0) < budget) ? (cyc - r0) : budget);
      end else begin
        eru = 1'b0; edn = 1'b0; eb = 1'b1; ec = 0;
      end
      check_outs("txn", er, ea, ed, eru, eb, edn, CW'(ec));
      if (t_last >= 0 && cyc == t_last + budget + 3) begin
        ended = 1'b1;
        break;
      end
      acc_prev = -1;
      if (t_last < 0) begin
        v = (k < nb) && ($urandom_range(99) < vpct);
        cfg_valid_in = v;
        cfg_addr_in  = v ? ba[k] : AW'($urandom | 1);
        cfg_data_in  = v ? bd[k] : DW'($urandom);
        cfg_last_in  = v && (k == nb - 1);
        if (v && er) begin
          acc_prev = k;
          last_acc = cyc;
          if (k == nb - 1) t_last = cyc;
          k++;
        end
      end else begin
        // Stray beats outside LOAD must never reach the bus.
        send_beat(AW'($urandom | 1), DW'($urandom), 1'($urandom_range(1)));
        cfg_valid_in = 1'($urandom_range(1));
      end
      start_in = poke && (t_last >= 0) && (cyc >= t_last + 2) && (cyc <= t_last + budget + 2);
      run_cycles_in = start_in ? CW'($urandom) : CW'(budget);
      tick();
    end
    if (!ended) check("txn.timeout", 64'(0), 64'(1));
    idle_inputs();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_in = 1'b0;
    sel = 1'b0;

    // Vector table: 3 back-to-back beats, budget 4, plus a stray beat in the
    // start cycle that must not be accepted.
    tbl[0]  = mk(1, 4, 1, 'h99, 'h99, 0,  0, 0,    0,   0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 'h10, 'hA,  0,  1, 0,    0,   0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 'h20, 'hB,  0,  1, 'h10, 'hA, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 'h30, 'hC,  1,  1, 'h20, 'hB, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,    0,    0,  0, 'h30, 'hC, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   1, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   1, 1, 0, 2);
    tbl[8]  = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   1, 1, 0, 3);
    tbl[9]  = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   0, 1, 1, 4);
    tbl[10] = mk(0, 0, 0, 0,    0,    0,  0, 0,    0,   0, 0, 0, 4);

    do_reset("reset0");
    for (int i = 0; i < 11; i++) begin
      start_in = tbl[i].start; run_cycles_in = tbl[i].run;
      cfg_valid_in = tbl[i].valid; cfg_addr_in = tbl[i].addr;
      cfg_data_in = tbl[i].data; cfg_last_in = tbl[i].last;
      check_outs($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_addr, tbl[i].e_data,
                 tbl[i].e_run, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt);
      tick();
    end
    idle_inputs();

    // Reset mid-RUN at run cycle 5 of a budget-100 run.
    do_reset("reset1");
    start_in = 1'b1; run_cycles_in = CW'(100);
    tick();
    start_in = 1'b0;
    send_beat(AW'(5), DW'(6), 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 20 && o_cnt != CW'(5); i++) tick();
    check("midrun.count", 64'(o_cnt), 64'(5));
    check("midrun.run_en", 64'(o_run), 64'(1));
    reset_in = 1'b1;
    tick();
    check_outs("midrun_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    reset_in = 1'b0;
    tick();
    check_outs("after_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Abort during LOAD after one of three beats, then a clean restart.
    do_reset("reset2");
    start_in = 1'b1; run_cycles_in = CW'(4);
    tick();
    start_in = 1'b0;
    send_beat(AW'('h111), DW'('h222), 1'b0);
    check("abort_load.ready", 64'(o_ready), 64'(1));
    tick();
    send_beat(AW'('h333), DW'('h444), 1'b0);
    abort_in = 1'b1;
    check("abort_load.write1", 64'(o_addr), 64'('h111));
    tick();
    idle_inputs();
    check_outs("abort_load", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check_outs("abort_load_hold", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    run_txn(3, 4, 100, 1'b0);

    // Abort during RUN: count holds, enables drop.
    do_reset("reset3");
    start_in = 1'b1; run_cycles_in = CW'(10);
    tick();
    start_in = 1'b0;
    send_beat(AW'(7), DW'(8), 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 20 && o_cnt != CW'(3); i++) tick();
    check("abort_run.count", 64'(o_cnt), 64'(3));
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check_outs("abort_run", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, CW'(3));
    tick();
    check_outs("abort_run_hold", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, CW'(3));

    // Budget 0 with one beat, then start poked during RUN and DONE.
    run_txn(1, 0, 100, 1'b0);
    run_txn(2, 5, 100, 1'b1);

    // CFG_GAP=2 instance: three beats with valid held high.
    sel = 1'b1;
    do_reset("reset_gap");
    run_txn(3, 4, 100, 1'b0);
    run_txn(1, 0, 100, 1'b0);

    // Random transactions on both instances.
    for (int it = 0; it < 30; it++) begin
      bit ns;
      ns = 1'($urandom_range(1));
      if (ns != sel) begin
        sel = ns;
        do_reset("reset_rand");
      end
      run_txn($urandom_range(5, 1), $urandom_range(12), $urandom_range(100, 40),
              1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
